i2c_sensor_cfg_seq: RTL and testbench

Table-driven camera-sensor register configuration sequencer, the parametrised successor of the fixed OV5640 write-only loader. It walks an external register table and drives the codebase's byte-level I2C engine through its en/busy handshake. It supports 1- or 2-byte register addresses, optional read-back verify with retry, in-table delay and end opcodes, and re-triggerable runtime reconfiguration. It sits between the sensor register ROM and the I2C engine inside the camera RX wrapper.

---
 rtl/i2c_sensor_cfg_seq.sv | 202 ++++++++++++++++++++
 tb/tb_i2c_sensor_cfg_seq.sv | 254 +++++++++++++++++++++++++
 2 files changed

// File: rtl/i2c_sensor_cfg_seq.sv
// Table-driven camera-sensor register loader: walks a register ROM and drives the
// byte-level I2C engine through its en/busy handshake, with optional read-back verify.
module i2c_sensor_cfg_seq #(
    parameter logic [7:0] DEVID        = 8'h78,
    parameter int         ADDR_BYTES   = 2,
    parameter int         TBL_AW       = 9,
    parameter int         PWRUP_CYCLES = 256,
    parameter int         DELAY_TICK   = 25000,
    parameter int         MAX_RETRY    = 3
) (
    input  logic                         clk_i,
    input  logic                         rst_i,
    input  logic                         start,
    output logic [TBL_AW-1:0]            tbl_index,
    input  logic [2+8*ADDR_BYTES+8-1:0]  tbl_entry,
    output logic                         iic_en,
    output logic                         iic_mode,
    output logic [31:0]                  wr_data,
    output logic [7:0]                   wr_cnt,
    output logic [7:0]                   rd_cnt,
    input  logic [7:0]                   rd_data,
    input  logic                         iic_busy,
    output logic                         cfg_busy,
    output logic                         cfg_done,
    output logic                         cfg_err,
    output logic [TBL_AW-1:0]            err_index,
    output logic [7:0]                   err_count
);

    localparam int AW = 8 * ADDR_BYTES;
    localparam int CW = AW + 8;
    localparam int EW = CW + 2;

    typedef enum logic [1:0] {
        OP_WRITE        = 2'b00,
        OP_WRITE_VERIFY = 2'b01,
        OP_DELAY        = 2'b10,
        OP_END          = 2'b11
    } op_e;

    typedef enum logic [3:0] {
        S_PWRUP, S_FETCH, S_WR_REQ, S_WR_WAIT, S_RD_REQ,
        S_RD_WAIT, S_CHECK, S_DELAY, S_NEXT, S_DONE
    } state_e;

    state_e          state, state_n;
    logic [EW-1:0]   entry_q, cur_entry;
    logic [CW-1:0]   dly_units;
    logic [31:0]     tick_cnt;
    logic [7:0]      retry;
    logic [7:0]      rd_q;
    logic            busy_q;
    logic            busy_fall, retry_ok, mismatch, flag_entry, tick_last;
    op_e             fetch_op, cur_op;

    logic            en_n, mode_n;
    logic [31:0]     wr_data_n;
    logic [7:0]      wr_cnt_n, rd_cnt_n;

    // Byte 0 is the device address, then register address MSB first, then data.
    function automatic logic [31:0] pack_wr(input logic [EW-1:0] e);
        logic [31:0] w;
        w = '0;
        w[7:0] = DEVID;
        for (int i = 0; i < ADDR_BYTES; i++)
            w[8*(i+1) +: 8] = e[8 + 8*(ADDR_BYTES-1-i) +: 8];
        w[8*(ADDR_BYTES+1) +: 8] = e[7:0];
        return w;
    endfunction

    // The ROM output is only trusted during FETCH; afterwards the latched copy is used.
    assign cur_entry  = (state == S_FETCH) ? tbl_entry : entry_q;
    assign fetch_op   = op_e'(tbl_entry[EW-1 -: 2]);
    assign cur_op     = op_e'(entry_q[EW-1 -: 2]);
    assign busy_fall  = busy_q && !iic_busy;
    assign retry_ok   = retry < 8'(MAX_RETRY);
    assign mismatch   = rd_q != entry_q[7:0];
    assign flag_entry = (state == S_CHECK) && mismatch && !retry_ok;
    assign tick_last  = tick_cnt == 32'(DELAY_TICK - 1);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) state <= S_PWRUP;
        else       state <= state_n;
    end

    // NOTE: every variable assigned in always_comb gets a default first, so no path
    // through the case statement can leave it unassigned and infer a latch.
    always_comb begin
        state_n = state;
        case (state)
            S_PWRUP:   if (tick_cnt == 32'(PWRUP_CYCLES - 1)) state_n = S_FETCH;
            S_FETCH: begin
                case (fetch_op)
                    OP_WRITE, OP_WRITE_VERIFY: state_n = S_WR_REQ;
                    OP_DELAY: state_n = (tbl_entry[CW-1:0] == '0) ? S_NEXT : S_DELAY;
                    default:  state_n = S_DONE;
                endcase
            end
            S_WR_REQ:  if (iic_busy) state_n = S_WR_WAIT;
            S_WR_WAIT: if (busy_fall) state_n = (cur_op == OP_WRITE_VERIFY) ? S_RD_REQ : S_NEXT;
            S_RD_REQ:  if (iic_busy) state_n = S_RD_WAIT;
            S_RD_WAIT: if (busy_fall) state_n = S_CHECK;
            S_CHECK:   state_n = (mismatch && retry_ok) ? S_WR_REQ : S_NEXT;
            S_DELAY:   if (tick_last && dly_units == CW'(1)) state_n = S_NEXT;
            S_NEXT:    state_n = (tbl_index == '1) ? S_DONE : S_FETCH;
            S_DONE:    if (start) state_n = S_FETCH;
            default:   state_n = S_PWRUP;
        endcase

        en_n      = 1'b0;
        mode_n    = 1'b0;
        wr_data_n = '0;
        wr_cnt_n  = '0;
        rd_cnt_n  = '0;
        case (state_n)
            S_WR_REQ, S_WR_WAIT: begin
                en_n      = (state_n == S_WR_REQ);
                wr_data_n = pack_wr(cur_entry);
                wr_cnt_n  = 8'(ADDR_BYTES + 2);
            end
            S_RD_REQ, S_RD_WAIT: begin
                en_n      = (state_n == S_RD_REQ);
                mode_n    = 1'b1;
                wr_data_n = pack_wr(cur_entry);
                wr_cnt_n  = 8'(ADDR_BYTES + 1);
                rd_cnt_n  = 8'd1;
            end
            default: ;
        endcase
    end

    // Outputs are registered from the next state so iic_en drops on the same edge
    // that the request state is left.
    // NOTE: sequential state uses non-blocking assignments so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iic_en   <= 1'b0;
            iic_mode <= 1'b0;
            wr_data  <= '0;
            wr_cnt   <= '0;
            rd_cnt   <= '0;
            cfg_busy <= 1'b0;
            cfg_done <= 1'b0;
        end else begin
            iic_en   <= en_n;
            iic_mode <= mode_n;
            wr_data  <= wr_data_n;
            wr_cnt   <= wr_cnt_n;
            rd_cnt   <= rd_cnt_n;
            cfg_busy <= (state_n != S_DONE);
            cfg_done <= (state_n == S_DONE);
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            entry_q   <= '0;
            dly_units <= '0;
            tick_cnt  <= '0;
            retry     <= '0;
            rd_q      <= '0;
            busy_q    <= 1'b0;
            tbl_index <= '0;
        end else begin
            busy_q <= iic_busy;
            if ((state == S_PWRUP && state_n == S_PWRUP) || (state == S_DELAY && !tick_last))
                tick_cnt <= tick_cnt + 32'd1;
            else
                tick_cnt <= '0;
            if (state == S_FETCH) begin
                entry_q   <= tbl_entry;
                dly_units <= tbl_entry[CW-1:0];
            end else if (state == S_DELAY && tick_last) begin
                dly_units <= dly_units - CW'(1);
            end
            if (state == S_RD_WAIT && busy_fall) rd_q <= rd_data;
            if (state == S_CHECK && mismatch && retry_ok) retry <= retry + 8'd1;
            else if (state == S_NEXT)                      retry <= '0;
            if (state == S_NEXT)                tbl_index <= tbl_index + 1'b1;
            else if (state == S_DONE && start)  tbl_index <= '0;
        end
    end

    // Error record is per run: cleared by start, first failing index kept.
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            cfg_err   <= 1'b0;
            err_index <= '0;
            err_count <= '0;
        end else if (state == S_DONE && start) begin
            cfg_err   <= 1'b0;
            err_index <= '0;
            err_count <= '0;
        end else if (flag_entry) begin
            cfg_err <= 1'b1;
            if (!cfg_err) err_index <= tbl_index;
            if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        end
    end

endmodule

// File: tb/tb_i2c_sensor_cfg_seq.sv
// Directed bench for i2c_sensor_cfg_seq: model I2C engine, 2-byte and 1-byte address builds.
module tb_i2c_sensor_cfg_seq;

    logic clk_i = 1'b0;
    logic rst_i = 1'b1;
    logic start = 1'b0;
    always #5 clk_i = ~clk_i;

    int cyc = 0;
    always @(posedge clk_i) cyc <= cyc + 1;

    // ---------------- DUT with 2-byte register addresses ----------------
    logic [8:0]  tbl_index, err_index;
    logic [25:0] tbl_entry;
    logic        iic_en, iic_mode, iic_busy, cfg_busy, cfg_done, cfg_err;
    logic [31:0] wr_data;
    logic [7:0]  wr_cnt, rd_cnt, rd_data, err_count;

    i2c_sensor_cfg_seq #(
        .DEVID(8'h78), .ADDR_BYTES(2), .TBL_AW(9),
        .PWRUP_CYCLES(256), .DELAY_TICK(10), .MAX_RETRY(3)
    ) u_dut (
        .clk_i(clk_i), .rst_i(rst_i), .start(start),
        .tbl_index(tbl_index), .tbl_entry(tbl_entry),
        .iic_en(iic_en), .iic_mode(iic_mode), .wr_data(wr_data),
        .wr_cnt(wr_cnt), .rd_cnt(rd_cnt), .rd_data(rd_data), .iic_busy(iic_busy),
        .cfg_busy(cfg_busy), .cfg_done(cfg_done), .cfg_err(cfg_err),
        .err_index(err_index), .err_count(err_count)
    );

    function automatic logic [25:0] tbl0(input logic [8:0] i);
        case (i)
            9'd0:    return {2'b00, 16'h3008, 8'h82};
            9'd1:    return {2'b10, 16'h0000, 8'h00};
            9'd2:    return {2'b01, 16'h4300, 8'h30};
            9'd3:    return {2'b00, 16'h3100, 8'h11};
            9'd4:    return {2'b10, 16'h0000, 8'h02};
            9'd5:    return {2'b01, 16'h5000, 8'hAA};
            9'd6:    return {2'b00, 16'h3200, 8'h22};
            default: return {2'b11, 24'h000000};
        endcase
    endfunction
    assign tbl_entry = tbl0(tbl_index);

    typedef struct {
        logic [31:0] data;
        logic        mode;
        logic [7:0]  wcnt;
        logic [7:0]  rcnt;
        int          cyc;
    } tx_t;

    tx_t  tx_q[$];
    int   end_q[$];
    logic [3:0] eng_cnt;
    logic [7:0] last_wr, rd_pend;

    // Engine model: 10 busy cycles; register 0x5000 always reads back 0x00.
    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iic_busy <= 1'b0;
            eng_cnt  <= '0;
            rd_data  <= '0;
        end else if (!iic_busy) begin
            if (iic_en) begin
                iic_busy <= 1'b1;
                eng_cnt  <= 4'd10;
                tx_q.push_back('{wr_data, iic_mode, wr_cnt, rd_cnt, cyc});
                if (!iic_mode) last_wr <= wr_data[31:24];
                else rd_pend <= ({wr_data[15:8], wr_data[23:16]} == 16'h5000) ? 8'h00 : last_wr;
            end
        end else begin
            eng_cnt <= eng_cnt - 4'd1;
            if (eng_cnt == 4'd1) begin
                iic_busy <= 1'b0;
                rd_data  <= rd_pend;
                end_q.push_back(cyc);
            end
        end
    end

    // ---------------- DUT with 1-byte register addresses ----------------
    logic [8:0]  tbl_index1, err_index1;
    logic [17:0] tbl_entry1;
    logic        iic_en1, iic_mode1, iic_busy1, cfg_busy1, cfg_done1, cfg_err1;
    logic [31:0] wr_data1, wd1;
    logic [7:0]  wr_cnt1, rd_cnt1, err_count1, wc1;
    logic [7:0]  rd_data1 = 8'h00;
    logic [3:0]  eng_cnt1;
    int          n_tx1 = 0;

    i2c_sensor_cfg_seq #(
        .DEVID(8'h78), .ADDR_BYTES(1), .TBL_AW(9),
        .PWRUP_CYCLES(256), .DELAY_TICK(10), .MAX_RETRY(3)
    ) u_dut1 (
        .clk_i(clk_i), .rst_i(rst_i), .start(1'b0),
        .tbl_index(tbl_index1), .tbl_entry(tbl_entry1),
        .iic_en(iic_en1), .iic_mode(iic_mode1), .wr_data(wr_data1),
        .wr_cnt(wr_cnt1), .rd_cnt(rd_cnt1), .rd_data(rd_data1), .iic_busy(iic_busy1),
        .cfg_busy(cfg_busy1), .cfg_done(cfg_done1), .cfg_err(cfg_err1),
        .err_index(err_index1), .err_count(err_count1)
    );

    assign tbl_entry1 = (tbl_index1 == 9'd0) ? {2'b00, 8'h30, 8'h5A} : {2'b11, 16'h0000};

    always @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            iic_busy1 <= 1'b0;
            eng_cnt1  <= '0;
        end else if (!iic_busy1) begin
            if (iic_en1) begin
                iic_busy1 <= 1'b1;
                eng_cnt1  <= 4'd10;
                n_tx1     <= n_tx1 + 1;
                wd1       <= wr_data1;
                wc1       <= wr_cnt1;
            end
        end else begin
            eng_cnt1 <= eng_cnt1 - 4'd1;
            if (eng_cnt1 == 4'd1) iic_busy1 <= 1'b0;
        end
    end

    // ---------------- checking ----------------
    int n_cmp  = 0;
    int n_fail = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_done(input int budget);
        int i = 0;
        while (!cfg_done && i < budget) begin
            @(negedge clk_i);
            i++;
        end
        check("done_within_budget", {31'd0, cfg_done}, 32'd1);
    endtask

    task automatic pulse_start();
        @(negedge clk_i);
        start = 1'b1;
        @(negedge clk_i);
        start = 1'b0;
    endtask

    initial begin
        int rel, base, base_e, n_w5, n_r5, k;

        // Reset state
        repeat (3) @(negedge clk_i);
        check("rst_iic_en",   {31'd0, iic_en},   32'd0);
        check("rst_cfg_busy", {31'd0, cfg_busy}, 32'd0);
        check("rst_cfg_done", {31'd0, cfg_done}, 32'd0);
        check("rst_wr_data",  wr_data,           32'd0);
        check("rst_tbl_index", {23'd0, tbl_index}, 32'd0);

        // Run 1: full table after power-up wait
        rel = cyc;
        rst_i = 1'b0;
        wait_done(3000);
        check("run1_tx_count", tx_q.size(), 32'd13);
        if (tx_q.size() >= 13 && end_q.size() >= 4) begin
            check("pwrup_first_accept", tx_q[0].cyc - rel, 32'd257);
            check("w0_data",   tx_q[0].data, 32'h82083078);
            check("w0_cnt",    {24'd0, tx_q[0].wcnt}, 32'd4);
            check("w0_mode",   {31'd0, tx_q[0].mode}, 32'd0);
            check("wv_wr_data", tx_q[1].data, 32'h30004378);
            check("wv_wr_mode", {31'd0, tx_q[1].mode}, 32'd0);
            check("wv_rd_mode", {31'd0, tx_q[2].mode}, 32'd1);
            check("wv_rd_wcnt", {24'd0, tx_q[2].wcnt}, 32'd3);
            check("wv_rd_rcnt", {24'd0, tx_q[2].rcnt}, 32'd1);
            check("gap_delay0", tx_q[1].cyc - end_q[0], 32'd6);
            check("gap_delay2", tx_q[4].cyc - end_q[3], 32'd26);
            check("gap_delta",  (tx_q[4].cyc - end_q[3]) - (tx_q[1].cyc - end_q[0]), 32'd20);
            check("last_write", tx_q[12].data, 32'h22003278);
        end
        n_w5 = 0;
        n_r5 = 0;
        foreach (tx_q[i]) begin
            if ({tx_q[i].data[15:8], tx_q[i].data[23:16]} == 16'h5000) begin
                if (tx_q[i].mode) n_r5++;
                else              n_w5++;
            end
        end
        check("retry_writes", n_w5, 32'd4);
        check("retry_reads",  n_r5, 32'd4);
        check("run1_cfg_err",   {31'd0, cfg_err},  32'd1);
        check("run1_err_index", {23'd0, err_index}, 32'd5);
        check("run1_err_count", {24'd0, err_count}, 32'd1);
        check("run1_cfg_busy",  {31'd0, cfg_busy}, 32'd0);
        check("run1_end_index", {23'd0, tbl_index}, 32'd7);

        // 1-byte address build: single write then END
        check("ab1_done",    {31'd0, cfg_done1}, 32'd1);
        check("ab1_tx",      n_tx1, 32'd1);
        check("ab1_wr_data", wd1, 32'h005A3078);
        check("ab1_wr_cnt",  {24'd0, wc1}, 32'd3);

        // Run 2: start after done clears errors; start while busy is ignored
        base = tx_q.size();
        pulse_start();
        check("restart_done_low", {31'd0, cfg_done}, 32'd0);
        check("restart_busy",     {31'd0, cfg_busy}, 32'd1);
        check("restart_err_clr",  {31'd0, cfg_err},  32'd0);
        check("restart_cnt_clr",  {24'd0, err_count}, 32'd0);
        k = 0;
        while (tx_q.size() < base + 3 && k < 1000) begin
            @(negedge clk_i);
            k++;
        end
        check("busy_before_start", {31'd0, cfg_busy}, 32'd1);
        pulse_start();
        wait_done(3000);
        check("run2_tx_count",  tx_q.size() - base, 32'd13);
        check("run2_err_count", {24'd0, err_count}, 32'd1);
        check("run2_err_index", {23'd0, err_index}, 32'd5);

        // Run 3: reset in the middle of a transaction
        pulse_start();
        k = 0;
        while (!(tx_q.size() >= base + 17 && iic_busy) && k < 1000) begin
            @(negedge clk_i);
            k++;
        end
        check("mid_tx_busy", {31'd0, iic_busy}, 32'd1);
        rst_i = 1'b1;
        #1;
        check("abort_iic_en",    {31'd0, iic_en},   32'd0);
        check("abort_cfg_busy",  {31'd0, cfg_busy}, 32'd0);
        check("abort_tbl_index", {23'd0, tbl_index}, 32'd0);
        check("abort_wr_data",   wr_data, 32'd0);
        check("abort_wr_cnt",    {24'd0, wr_cnt}, 32'd0);
        @(negedge clk_i);
        base_e = tx_q.size();
        rel = cyc;
        rst_i = 1'b0;
        wait_done(3000);
        check("run3_tx_count", tx_q.size() - base_e, 32'd13);
        if (tx_q.size() > base_e) begin
            check("run3_pwrup", tx_q[base_e].cyc - rel, 32'd257);
            check("run3_first", tx_q[base_e].data, 32'h82083078);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
